instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute sequencer for the simple processor core.
//  Fetches an instruction word over a req/rdy memory handshake, holds it in the IR and presents its opcode to control_unit.
//  Gates control_unit's register/PC writes with a one-cycle exec_en strobe, stretches long-class ops and halts on the HALT opcode.
// PARAMETERS
//  INSTR_W   16  instruction width; opcode = ir[INSTR_W-1 -: 5]
//  LONG_CYC  3   EXEC cycles for long-class opcodes (opcode[4:3]==2'b10); legal >=1
//  CNT_W     16  width of retired-instruction counter
//  TIMEOUT   15  fetch watchdog limit in cycles (used only with SEQ_TIMEOUT_EN)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous active-high reset
//  run        in   1        start/continue; sampled in IDLE and at end of EXEC
//  mem_rdy    in   1        memory has valid mem_rdata this cycle
//  mem_rdata  in   INSTR_W  fetched instruction word
//  mem_req    out  1        fetch request, held until mem_rdy
//  ir         out  INSTR_W  instruction register
//  opcode     out  5        ir opcode field, to control_unit
//  exec_en    out  1        one-cycle strobe in final EXEC cycle; ANDed with load_pc/pc_inc/gpr_load
//  exec_busy  out  1        high in every EXEC cycle
//  flag_ld    out  1        latch c/z/v; = exec_en for ALU-class opcodes 5'b00001..5'b01110
//  halted     out  1        high in HALT
//  fetch_err  out  1        watchdog fired (SEQ_TIMEOUT_EN only; else tied 0)
//  instr_cnt  out  CNT_W    retired-instruction count
// BEHAVIOUR
//  Reset: state=IDLE; mem_req, exec_en, exec_busy, flag_ld, halted, fetch_err = 0; ir = 0; instr_cnt = 0.
//  rst wins over every other input in the same cycle; mid-operation reset abandons the fetch/exec (mem_req low after that edge).
//  States: IDLE -> FETCH -> DECODE -> EXEC -> (FETCH | IDLE); DECODE -> HALT.
//  IDLE: outputs low; run=1 -> FETCH next cycle.
//  FETCH: mem_req=1; on mem_rdy: ir<=mem_rdata, -> DECODE. mem_rdy outside FETCH is ignored.
//  DECODE: 1 cycle, opcode stable for control_unit. opcode==5'b00000 -> HALT, else -> EXEC, exec counter loads N-1.
//  EXEC: N = LONG_CYC if opcode[4:3]==2'b10, else 1. Counter decrements; exec_en/flag_ld only when counter==0.
//  End of EXEC: instr_cnt+1 (wraps 2^CNT_W-1 -> 0); run=1 -> FETCH, run=0 -> IDLE. run is not sampled mid-EXEC.
//  HALT: halted=1, all strobes 0; exits only by rst. HALT does not increment instr_cnt.
//  Latency, mem_rdy in first FETCH cycle: short op issues exec_en 2 cycles after the rdy edge, next mem_req on the following cycle; 1 instr / 3 cycles.
//  ir holds its value from DECODE until the next mem_rdy capture.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined: counter runs while in FETCH without mem_rdy; after TIMEOUT consecutive cycles -> HALT with fetch_err=1 (sticky until rst).
//  mem_rdy on cycle TIMEOUT itself is accepted normally.
//  SEQ_TIMEOUT_EN undefined: FETCH waits indefinitely; fetch_err tied 0; no watchdog logic.
// STRUCTURE
//  Shared package cpu_seq_pkg: state encoding (IDLE, FETCH, DECODE, EXEC, HALT), OP_HALT=5'b00000,
//  opcode-class helpers is_long_op() and is_alu_op(); shared with control_unit.
//  One sub-module, fetch_watchdog (counter + compare), instantiated only under SEQ_TIMEOUT_EN.
//  Exec counter and FSM stay inline.
// TESTING
//  1 Reset then run=1, mem_rdy=1 immediately, mem_rdata opcode 5'b00001 -> exec_en and flag_ld high 1 cycle, instr_cnt=1.
//  2 Long op 5'b10010, LONG_CYC=3 -> exec_busy 3 cycles, exec_en only 3rd, flag_ld=0, then mem_req=1.
//  3 mem_rdy delayed 4 cycles -> mem_req held 4+1 cycles, ir unchanged until capture; spurious mem_rdy in EXEC ignored.
//  4 Opcode 5'b00000 -> HALT, halted=1, mem_req=0 with run=1 for 20 cycles; rst returns IDLE, halted=0.
//  5 rst asserted mid-EXEC of long op -> next cycle IDLE, exec_en never pulses, instr_cnt=0.
//  6 SEQ_TIMEOUT_EN, TIMEOUT=15, mem_rdy never -> fetch_err=1, halted=1 after 15 FETCH cycles; without macro mem_req stays high.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared sequencer state encoding and opcode-class helpers
//
// Purpose: definitions shared between instr_sequencer and control_unit.
//   seq_state_t  : IDLE, FETCH, DECODE, EXEC, HALT
//   OP_HALT      : opcode that parks the core until reset
//   is_long_op() : opcode[4:3] == 2'b10, executes for LONG_CYC cycles
//   is_alu_op()  : opcodes 5'b00001..5'b01110, update c/z/v flags
// Ports: none (package).
package cpu_seq_pkg;

    localparam int OP_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } seq_state_t;

    localparam logic [OP_W-1:0] OP_HALT = 5'b00000;

    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        return (op >> 3) == 5'd2;
    endfunction

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op >= 5'd1) && (op <= 5'd14);
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - counts consecutive unanswered fetch cycles
//
// Purpose: fires when the sequencer has sat in FETCH for TIMEOUT consecutive
//   cycles without mem_rdy. A mem_rdy in cycle TIMEOUT suppresses the fire,
//   so a late-but-in-time response is still accepted.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   active   in   sequencer is in FETCH this cycle
//   mem_rdy  in   memory answered this cycle
//   fire     out  this is the TIMEOUT-th consecutive cycle without an answer
module fetch_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_rdy,
    output logic fire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count;
    logic          waiting;

    assign waiting = active && !mem_rdy;
    // count holds the number of earlier waiting cycles, so cycle TIMEOUT sees TIMEOUT-1
    assign fire    = waiting && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (waiting && !fire) begin
            count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute sequencer for the simple core
//
// Purpose: fetches an instruction over a req/rdy handshake, holds it in ir,
//   presents the opcode to control_unit and gates its writes with a one-cycle
//   exec_en strobe. Long-class ops stretch EXEC to LONG_CYC cycles; OP_HALT
//   parks the sequencer until rst.
// Optional feature: define SEQ_TIMEOUT_EN to add the fetch watchdog (HALT with
//   sticky fetch_err after TIMEOUT unanswered FETCH cycles). Without it FETCH
//   waits indefinitely and fetch_err is tied low.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   run          start/continue; sampled in IDLE and in the last EXEC cycle
//   mem_rdy      mem_rdata valid this cycle (only looked at in FETCH)
//   mem_rdata    fetched instruction word
//   mem_req      fetch request, held through FETCH
//   ir, opcode   instruction register and its top 5 bits
//   exec_en      one-cycle strobe in the final EXEC cycle
//   exec_busy    high in every EXEC cycle
//   flag_ld      exec_en qualified by ALU-class opcode
//   halted       high in HALT
//   fetch_err    watchdog fired (sticky until rst)
//   instr_cnt    retired-instruction count, wraps
module instr_sequencer #(
    parameter int INSTR_W  = 16,
    parameter int LONG_CYC = 3,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               mem_rdy,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               mem_req,
    output logic [INSTR_W-1:0] ir,
    output logic [4:0]         opcode,
    output logic               exec_en,
    output logic               exec_busy,
    output logic               flag_ld,
    output logic               halted,
    output logic               fetch_err,
    output logic [CNT_W-1:0]   instr_cnt
);

    import cpu_seq_pkg::*;

    localparam int EC_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [EC_W-1:0] exec_cnt;
    logic            exec_last;
    logic            wd_fire;

    assign opcode    = ir[INSTR_W-1 -: 5];
    assign exec_last = (state == ST_EXEC) && (exec_cnt == '0);

`ifdef SEQ_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  (state == ST_FETCH),
        .mem_rdy (mem_rdy),
        .fire    (wd_fire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else if (wd_fire) begin
            fetch_err <= 1'b1;
        end
    end
`else
    assign wd_fire   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_rdy)      state_nxt = ST_DECODE;
                else if (wd_fire) state_nxt = ST_HALT;
            end
            ST_DECODE: begin
                state_nxt = (opcode == OP_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                // run is only consulted once the instruction retires
                if (exec_cnt == '0) state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        mem_req   = (state == ST_FETCH);
        exec_busy = (state == ST_EXEC);
        exec_en   = exec_last;
        flag_ld   = exec_last && is_alu_op(opcode);
        halted    = (state == ST_HALT);
    end

    // Instruction register, exec stretch counter, retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ir        <= '0;
            exec_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            if ((state == ST_FETCH) && mem_rdy) begin
                ir <= mem_rdata;
            end
            if (state == ST_DECODE) begin
                exec_cnt <= is_long_op(opcode) ? EC_W'(LONG_CYC - 1) : '0;
            end else if ((state == ST_EXEC) && (exec_cnt != '0)) begin
                exec_cnt <= exec_cnt - 1'b1;
            end
            if (exec_last) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    localparam int INSTR_W  = 16;
    localparam int LONG_CYC = 3;
    localparam int CNT_W    = 4;
    localparam int TIMEOUT  = 15;

    logic               clk = 1'b0;
    logic               rst;
    logic               run;
    logic               mem_rdy;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_req;
    logic [INSTR_W-1:0] ir;
    logic [4:0]         opcode;
    logic               exec_en;
    logic               exec_busy;
    logic               flag_ld;
    logic               halted;
    logic               fetch_err;
    logic [CNT_W-1:0]   instr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_sequencer #(
        .INSTR_W  (INSTR_W),
        .LONG_CYC (LONG_CYC),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_rdy   (mem_rdy),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .ir        (ir),
        .opcode    (opcode),
        .exec_en   (exec_en),
        .exec_busy (exec_busy),
        .flag_ld   (flag_ld),
        .halted    (halted),
        .fetch_err (fetch_err),
        .instr_cnt (instr_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; mem_rdy = 1'b0; mem_rdata = '0;
        tick(); tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if (exec_en !== 1'b0) begin errors++; $display("FAIL reset_exec_en got %b exp 0", exec_en); end
        checks++; if (exec_busy !== 1'b0) begin errors++; $display("FAIL reset_exec_busy got %b exp 0", exec_busy); end
        checks++; if (flag_ld !== 1'b0) begin errors++; $display("FAIL reset_flag_ld got %b exp 0", flag_ld); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_err got %b exp 0", fetch_err); end
        checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h exp 0000", ir); end
        checks++; if (instr_cnt !== 4'd0) begin errors++; $display("FAIL reset_instr_cnt got %0d exp 0", instr_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_short_op();
        run = 1'b1; mem_rdy = 1'b1; mem_rdata = 16'h0855;
        tick();  // FETCH, rdy present in the first cycle
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL short_fetch_req got %b exp 1", mem_req); end
        tick();  // DECODE
        checks++; if (ir !== 16'h0855) begin errors++; $display("FAIL short_ir got %h exp 0855", ir); end
        checks++; if (opcode !== 5'b00001) begin errors++; $display("FAIL short_opcode got %b exp 00001", opcode); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL short_decode_req got %b exp 0", mem_req); end
        checks++; if (exec_en !== 1'b0) begin errors++; $display("FAIL short_decode_en got %b exp 0", exec_en); end
        run = 1'b0;
        tick();  // EXEC
        checks++; if (exec_en !== 1'b1) begin errors++; $display("FAIL short_exec_en got %b exp 1", exec_en); end
        checks++; if (flag_ld !== 1'b1) begin errors++; $display("FAIL short_flag_ld got %b exp 1", flag_ld); end
        checks++; if (exec_busy !== 1'b1) begin errors++; $display("FAIL short_exec_busy got %b exp 1", exec_busy); end
        tick();  // IDLE
        checks++; if (exec_en !== 1'b0) begin errors++; $display("FAIL short_after_en got %b exp 0", exec_en); end
        checks++; if (flag_ld !== 1'b0) begin errors++; $display("FAIL short_after_flag got %b exp 0", flag_ld); end
        checks++; if (instr_cnt !== 4'd1) begin errors++; $display("FAIL short_instr_cnt got %0d exp 1", instr_cnt); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL short_idle_req got %b exp 0", mem_req); end
        mem_rdy = 1'b0;
    endtask

    task automatic test_long_op();
        run = 1'b1; mem_rdata = 16'h9000;
        tick();  // FETCH
        mem_rdy = 1'b1;
        tick();  // DECODE
        mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (exec_busy !== 1'b1) begin errors++; $display("FAIL long_busy[%0d] got %b exp 1", i, exec_busy); end
            checks++; if (exec_en !== (i == 2)) begin errors++; $display("FAIL long_en[%0d] got %b exp %b", i, exec_en, (i == 2)); end
            checks++; if (flag_ld !== 1'b0) begin errors++; $display("FAIL long_flag[%0d] got %b exp 0", i, flag_ld); end
        end
        tick();  // FETCH again, run held high
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL long_next_req got %b exp 1", mem_req); end
        checks++; if (exec_busy !== 1'b0) begin errors++; $display("FAIL long_busy_end got %b exp 0", exec_busy); end
        checks++; if (instr_cnt !== 4'd2) begin errors++; $display("FAIL long_instr_cnt got %0d exp 2", instr_cnt); end
    endtask

    task automatic test_delayed_rdy();
        mem_rdata = 16'h0A00;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL delay_req[%0d] got %b exp 1", i, mem_req); end
            checks++; if (ir !== 16'h9000) begin errors++; $display("FAIL delay_ir_hold[%0d] got %h exp 9000", i, ir); end
            tick();
        end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL delay_req_5th got %b exp 1", mem_req); end
        mem_rdy = 1'b1; run = 1'b0;
        tick();  // DECODE
        checks++; if (ir !== 16'h0A00) begin errors++; $display("FAIL delay_ir_cap got %h exp 0a00", ir); end
        mem_rdata = 16'hFFFF;  // mem_rdy stays high: must not be captured
        tick();  // EXEC
        checks++; if (exec_en !== 1'b1) begin errors++; $display("FAIL delay_exec_en got %b exp 1", exec_en); end
        tick();  // IDLE
        checks++; if (ir !== 16'h0A00) begin errors++; $display("FAIL spurious_rdy_ir got %h exp 0a00", ir); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL delay_idle_req got %b exp 0", mem_req); end
        checks++; if (instr_cnt !== 4'd3) begin errors++; $display("FAIL delay_instr_cnt got %0d exp 3", instr_cnt); end
        checks++; if (exec_busy !== 1'b0) begin errors++; $display("FAIL delay_idle_busy got %b exp 0", exec_busy); end
        mem_rdy = 1'b0;
    endtask

    task automatic test_halt();
        run = 1'b1; mem_rdy = 1'b1; mem_rdata = 16'h0123;
        tick(); tick(); tick();  // FETCH, DECODE, HALT
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_enter got %b exp 1", halted); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold[%0d] got %b exp 1", i, halted); end
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL halt_req[%0d] got %b exp 0", i, mem_req); end
            checks++; if (exec_en !== 1'b0) begin errors++; $display("FAIL halt_en[%0d] got %b exp 0", i, exec_en); end
            checks++; if (exec_busy !== 1'b0) begin errors++; $display("FAIL halt_busy[%0d] got %b exp 0", i, exec_busy); end
        end
        checks++; if (instr_cnt !== 4'd3) begin errors++; $display("FAIL halt_instr_cnt got %0d exp 3", instr_cnt); end
        rst = 1'b1; run = 1'b0; mem_rdy = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_rst_halted got %b exp 0", halted); end
        checks++; if (instr_cnt !== 4'd0) begin errors++; $display("FAIL halt_rst_cnt got %0d exp 0", instr_cnt); end
        checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL halt_rst_ir got %h exp 0000", ir); end
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL halt_idle_req got %b exp 0", mem_req); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_idle_halted got %b exp 0", halted); end
    endtask

    task automatic test_reset_mid_exec();
        run = 1'b1; mem_rdy = 1'b1; mem_rdata = 16'h0800;
        tick(); tick();  // FETCH, DECODE of short op
        mem_rdata = 16'h9000;
        tick();  // EXEC of short op
        tick();  // FETCH of long op
        checks++; if (instr_cnt !== 4'd1) begin errors++; $display("FAIL midrst_pre_cnt got %0d exp 1", instr_cnt); end
        tick();  // DECODE of long op
        mem_rdy = 1'b0;
        tick();  // first EXEC cycle
        checks++; if (exec_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b exp 1", exec_busy); end
        rst = 1'b1; mem_rdy = 1'b1;  // rst must win over run and mem_rdy
        tick();
        checks++; if (exec_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after got %b exp 0", exec_busy); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_req got %b exp 0", mem_req); end
        checks++; if (exec_en !== 1'b0) begin errors++; $display("FAIL midrst_en got %b exp 0", exec_en); end
        checks++; if (instr_cnt !== 4'd0) begin errors++; $display("FAIL midrst_cnt got %0d exp 0", instr_cnt); end
        rst = 1'b0; run = 1'b0; mem_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (exec_en !== 1'b0) begin errors++; $display("FAIL midrst_idle_en[%0d] got %b exp 0", i, exec_en); end
            checks++; if (instr_cnt !== 4'd0) begin errors++; $display("FAIL midrst_idle_cnt[%0d] got %0d exp 0", i, instr_cnt); end
        end
    endtask

    task automatic test_back_to_back();
        run = 1'b1; mem_rdy = 1'b1; mem_rdata = 16'h0800;
        tick();  // FETCH
        // steady state: DECODE, EXEC, FETCH repeating; 16 retirements wrap the 4-bit count
        for (int i = 0; i < 48; i++) begin
            tick();
            checks++; if (exec_en !== (i % 3 == 1)) begin errors++; $display("FAIL b2b_en[%0d] got %b exp %b", i, exec_en, (i % 3 == 1)); end
            checks++; if (mem_req !== (i % 3 == 2)) begin errors++; $display("FAIL b2b_req[%0d] got %b exp %b", i, mem_req, (i % 3 == 2)); end
            if (i == 44) begin
                checks++; if (instr_cnt !== 4'd15) begin errors++; $display("FAIL b2b_cnt_max got %0d exp 15", instr_cnt); end
            end
        end
        checks++; if (instr_cnt !== 4'd0) begin errors++; $display("FAIL b2b_cnt_wrap got %0d exp 0", instr_cnt); end
        run = 1'b0;
        tick(); tick(); tick();  // DECODE, EXEC, IDLE
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL b2b_drain_req got %b exp 0", mem_req); end
        checks++; if (instr_cnt !== 4'd1) begin errors++; $display("FAIL b2b_drain_cnt got %0d exp 1", instr_cnt); end
        mem_rdy = 1'b0;
    endtask

    task automatic test_timeout();
        rst = 1'b1; run = 1'b0; mem_rdy = 1'b0;
        tick();
        rst = 1'b0; run = 1'b1;
        tick();  // FETCH cycle 1
`ifdef SEQ_TIMEOUT_EN
        for (int k = 1; k < TIMEOUT; k++) begin
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL wd_req[%0d] got %b exp 1", k, mem_req); end
            checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL wd_early_err[%0d] got %b exp 0", k, fetch_err); end
            tick();
        end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL wd_last_halted got %b exp 0", halted); end
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL wd_halted got %b exp 1", halted); end
        checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL wd_fetch_err got %b exp 1", fetch_err); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wd_halt_req got %b exp 0", mem_req); end
        tick(); tick(); tick();
        checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b exp 1", fetch_err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL wd_rst_err got %b exp 0", fetch_err); end
        tick();  // FETCH cycle 1
        for (int k = 1; k < TIMEOUT; k++) tick();
        mem_rdy = 1'b1; mem_rdata = 16'h0800; run = 1'b0;  // answer in cycle TIMEOUT
        tick();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL wd_edge_halted got %b exp 0", halted); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL wd_edge_err got %b exp 0", fetch_err); end
        checks++; if (ir !== 16'h0800) begin errors++; $display("FAIL wd_edge_ir got %h exp 0800", ir); end
        mem_rdy = 1'b0;
`else
        for (int k = 0; k < 30; k++) begin
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL nowd_req[%0d] got %b exp 1", k, mem_req); end
            checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL nowd_err[%0d] got %b exp 0", k, fetch_err); end
            checks++; if (halted !== 1'b0) begin errors++; $display("FAIL nowd_halted[%0d] got %b exp 0", k, halted); end
            tick();
        end
`endif
        rst = 1'b1; run = 1'b0; mem_rdy = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mem_rdy = 1'b0; mem_rdata = '0;
        test_reset();
        test_short_op();
        test_long_op();
        test_delayed_rdy();
        test_halt();
        test_reset_mid_exec();
        test_back_to_back();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
